// File: rtl/sp_if_ddr_access_fac05.sv
// sp_if_ddr_access_fac05: runs one latched DDR command as Avalon-MM bursts between DDR and the Rx/Tx FIFOs.
module sp_if_ddr_access_fac05 #(
  parameter int          BURST_MAX   = 64,
  parameter logic [26:0] AREA_STRIDE = 27'h0400000
) (
  input  logic         i_clk156m,
  input  logic         i_arst,
  input  logic         i_ddr_start,
  input  logic         i_ddr_wxr,
  input  logic [3:0]   i_ddr_area,
  input  logic [26:0]  i_ddr_addr,
  input  logic [31:0]  i_ddr_size,
  output logic         o_ddr_endp,
  output logic         o_busy,
  output logic [26:0]  o_avm_address,
  output logic         o_avm_read,
  output logic         o_avm_write,
  output logic [6:0]   o_avm_burstcount,
  output logic [127:0] o_avm_writedata,
  input  logic         i_avm_waitrequest,
  input  logic [127:0] i_avm_readdata,
  input  logic         i_avm_readdatavalid,
  input  logic [127:0] i_txbuf_data,
  input  logic         i_txbuf_empty,
  output logic         o_txbuf_rdack,
  output logic [127:0] o_rxfifo_wdata,
  output logic         o_rxfifo_wr,
  input  logic         i_rxfifo_afull
);
  typedef enum logic [2:0] {IDLE, LATCH, RD_CMD, RD_DATA, WR, DONE} state_t;
  state_t state_q, state_d;
  logic         start_q, start_d1_q, pend_q, rx_wr_q;
  logic [26:0]  addr_q, base;
  logic [27:0]  rem_q, blen, rem_next;
  logic [6:0]   cnt_q;
  logic [127:0] rx_data_q;
  logic         trig, rd_acc, wr_acc, rd_beat, beat, last_beat;
  logic [3:0]   unused_size;
  assign unused_size = i_ddr_size[3:0];
  // start is registered once before edge detection, so a zero-size command ends 3 cycles after its edge
  assign trig      = start_q & ~start_d1_q;
  assign base      = i_ddr_area <= 4'd3 ? 27'(i_ddr_area[1:0]) * AREA_STRIDE : '0;
  assign blen      = rem_q < 28'(BURST_MAX) ? rem_q : 28'(BURST_MAX);
  assign rem_next  = rem_q - blen;
  assign rd_acc    = o_avm_read & ~i_avm_waitrequest;
  assign wr_acc    = o_avm_write & ~i_avm_waitrequest;
  assign rd_beat   = state_q == RD_DATA & i_avm_readdatavalid;
  assign beat      = rd_beat | wr_acc;
  assign last_beat = cnt_q + 7'd1 == blen[6:0];
  always_ff @(posedge i_clk156m or posedge i_arst)
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = trig ? LATCH : IDLE;
      LATCH:   state_d = i_ddr_size[31:4] == '0 ? DONE : i_ddr_wxr ? WR : RD_CMD;
      RD_CMD:  state_d = rd_acc ? RD_DATA : RD_CMD;
      RD_DATA: state_d = rd_beat && last_beat ? (rem_next == '0 ? DONE : RD_CMD) : RD_DATA;
      WR:      state_d = wr_acc && last_beat ? (rem_next == '0 ? DONE : WR) : WR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // a read request already on the bus stays up even if afull rises while it waits
  always_comb begin
    o_avm_read       = state_q == RD_CMD && (!i_rxfifo_afull || pend_q);
    o_avm_write      = state_q == WR && !i_txbuf_empty;
    o_avm_address    = o_avm_read || o_avm_write ? addr_q : '0;
    o_avm_burstcount = o_avm_read || o_avm_write ? blen[6:0] : '0;
    o_avm_writedata  = o_avm_write ? i_txbuf_data : '0;
    o_txbuf_rdack    = wr_acc;
    o_ddr_endp       = state_q == DONE;
    o_busy           = state_q != IDLE;
    o_rxfifo_wr      = rx_wr_q;
    o_rxfifo_wdata   = rx_data_q;
  end
  always_ff @(posedge i_clk156m or posedge i_arst)
    if (i_arst) begin
      start_q    <= 1'b0;
      start_d1_q <= 1'b0;
      pend_q     <= 1'b0;
      rx_wr_q    <= 1'b0;
      rx_data_q  <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      start_q    <= i_ddr_start;
      start_d1_q <= start_q;
      pend_q     <= o_avm_read & i_avm_waitrequest;
      rx_wr_q    <= rd_beat;
      if (rd_beat) rx_data_q <= i_avm_readdata;
      if (state_q == LATCH) begin
        addr_q <= i_ddr_addr + base;
        rem_q  <= {i_ddr_size[31:4]};
        cnt_q  <= '0;
      end else if (beat) begin
        cnt_q <= last_beat ? 7'd0 : cnt_q + 7'd1;
        if (last_beat) begin
          addr_q <= addr_q + blen[26:0];
          rem_q  <= rem_next;
        end
      end
    end
endmodule

// File: tb/tb_sp_if_ddr_access_fac05.sv
// tb_sp_if_ddr_access_fac05: directed and randomized commands checked against a burst-list / FIFO-order model.
module tb_sp_if_ddr_access_fac05;
  localparam logic [26:0] STRIDE = 27'h0400000;
  localparam int NONE = 1000000;
  typedef struct packed {logic [26:0] a; logic [6:0] n;} burst_t;
  logic         clk = 1'b0, arst = 1'b1;
  logic         ddr_start = 0, ddr_wxr = 0;
  logic [3:0]   ddr_area = 0;
  logic [26:0]  ddr_addr = 0;
  logic [31:0]  ddr_size = 0;
  logic         endp, busy, avm_read, avm_write, waitreq = 0, rdv = 0, txempty = 1, rdack, rxwr, afull = 0;
  logic [26:0]  avm_addr;
  logic [6:0]   avm_bc;
  logic [127:0] avm_wdata, avm_rdata = 0, txdata = 0, rxwdata;
  int tests = 0, fails = 0;
  always #3 clk = ~clk;
  sp_if_ddr_access_fac05 dut (
    .i_clk156m(clk), .i_arst(arst), .i_ddr_start(ddr_start), .i_ddr_wxr(ddr_wxr),
    .i_ddr_area(ddr_area), .i_ddr_addr(ddr_addr), .i_ddr_size(ddr_size),
    .o_ddr_endp(endp), .o_busy(busy), .o_avm_address(avm_addr), .o_avm_read(avm_read),
    .o_avm_write(avm_write), .o_avm_burstcount(avm_bc), .o_avm_writedata(avm_wdata),
    .i_avm_waitrequest(waitreq), .i_avm_readdata(avm_rdata), .i_avm_readdatavalid(rdv),
    .i_txbuf_data(txdata), .i_txbuf_empty(txempty), .o_txbuf_rdack(rdack),
    .o_rxfifo_wdata(rxwdata), .o_rxfifo_wr(rxwr), .i_rxfifo_afull(afull)
  );
  task automatic chk(input string tag, input logic [320:0] o, input logic [320:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [320:0] all_out();
    return {endp, busy, avm_addr, avm_read, avm_write, avm_bc, avm_wdata, rdack, rxwdata, rxwr};
  endfunction
  task automatic run_cmd(input bit wxr, input logic [3:0] area, input logic [26:0] addr, input logic [31:0] size,
                         input int wpct, input int epct, input int af_from, input int af_len, input int hold, input int pulse_at);
    burst_t exp_b[$], obs_b[$], cur;
    logic [127:0] exp_rx[$], obs_rx[$], txq[$];
    logic [26:0] a;
    logic [27:0] rem, n;
    int total, post, endp_cnt, endp_lat, last_ev, pending, wbeats, wcnt;
    bit prev_wait;
    a = addr + (area <= 4'd3 ? 27'(area) * STRIDE : 27'd0);
    rem = size[31:4];
    total = int'(rem);
    while (rem > 0) begin
      n = rem > 28'd64 ? 28'd64 : rem;
      exp_b.push_back({a, n[6:0]});
      a = a + n[26:0];
      rem = rem - n;
    end
    if (wxr) repeat (total) txq.push_back(r128());
    post = 0; endp_cnt = 0; endp_lat = -1; last_ev = 0; pending = 0; wbeats = 0; wcnt = 0; prev_wait = 0; cur = '0;
    ddr_wxr = wxr; ddr_area = area; ddr_addr = addr; ddr_size = size; ddr_start = 1;
    for (int k = 0; k < 6000; k++) begin
      if (k == pulse_at) ddr_start = 0;
      if (k == pulse_at + 2) ddr_start = 1;
      if (endp_cnt > 0 && post >= hold) ddr_start = 0;
      waitreq = int'($urandom % 100) < wpct;
      txempty = txq.size() == 0 || int'($urandom % 100) < epct;
      txdata  = txq.size() > 0 ? txq[0] : r128();
      afull   = k >= af_from && k < af_from + af_len;
      avm_rdata = r128();
      rdv = 0;
      if (pending > 0 && $urandom % 3 != 0) begin
        rdv = 1; exp_rx.push_back(avm_rdata); pending--; last_ev = k;
      end else if (pending == 0 && $urandom % 6 == 0) rdv = 1;
      #1;
      if (k == 2) chk("busy_latch", busy, 1'b1);
      if (post >= 1) chk("busy_after", busy, 1'b0);
      if (rxwr) obs_rx.push_back(rxwdata);
      if (endp) begin endp_cnt++; endp_lat = k - last_ev; end
      if (avm_read) chk("rd_afull", afull && !prev_wait, 1'b0);
      if (avm_read && !waitreq) begin obs_b.push_back({avm_addr, avm_bc}); pending += int'(avm_bc); end
      prev_wait = avm_read && waitreq;
      if (avm_write) chk("wr_empty", txempty, 1'b0);
      if (rdack) begin
        chk("rdack_acc", avm_write && !waitreq, 1'b1);
        if (txq.size() > 0) begin chk("wdata", avm_wdata, txq[0]); void'(txq.pop_front()); end
        if (wbeats == 0) begin cur = {avm_addr, avm_bc}; obs_b.push_back(cur); end
        else chk("wr_hold", {avm_addr, avm_bc}, cur);
        wbeats++; wcnt++; last_ev = k;
        if (wbeats == int'(cur.n)) wbeats = 0;
      end
      if (endp_cnt > 0) begin post++; if (post > hold + 4) break; end
      @(posedge clk); #1;
    end
    ddr_start = 0; rdv = 0; waitreq = 0; txempty = 1; afull = 0;
    chk("endp_cnt", endp_cnt, 1);
    chk("endp_lat", endp_lat, total == 0 ? 3 : 1);
    chk("nbursts", obs_b.size(), exp_b.size());
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) chk("burst", obs_b[i], exp_b[i]);
    if (wxr) chk("wbeats", wcnt, total);
    else chk("rbeats", obs_rx.size(), total);
    for (int i = 0; i < obs_rx.size() && i < exp_rx.size(); i++) chk("rxdata", obs_rx[i], exp_rx[i]);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    int n, seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", all_out(), 321'd0);
    arst = 0;
    repeat (2) @(posedge clk);
    #1;
    run_cmd(0, 4'd0, 27'h100, 32'h400, 0, 0, NONE, 0, 0, NONE);
    run_cmd(1, 4'd2, 27'h10, 32'hA00, 0, 0, NONE, 0, 0, NONE);
    run_cmd(0, 4'd0, 27'h2000, 32'h1230, 30, 0, 0, 50, 0, NONE);
    run_cmd(1, 4'd1, 27'h55, 32'h1F00, 30, 25, NONE, 0, 0, NONE);
    run_cmd(0, 4'd3, 27'h40, 32'h0F, 20, 0, NONE, 0, 0, NONE);
    run_cmd(1, 4'd0, 27'h40, 32'h0F, 20, 0, NONE, 0, 0, NONE);
    run_cmd(0, 4'd7, 27'h300, 32'h100, 20, 0, NONE, 0, 0, NONE);
    run_cmd(1, 4'd1, 27'h7FFFFF0, 32'h200, 10, 10, NONE, 0, 0, NONE);
    run_cmd(0, 4'd0, 27'h7FFFFF0, 32'h800, 10, 0, NONE, 0, 0, NONE);
    run_cmd(1, 4'd3, 27'h1000, 32'h800, 10, 10, NONE, 0, 200, NONE);
    run_cmd(0, 4'd2, 27'h80, 32'h600, 20, 0, NONE, 0, 0, 5);
    ddr_wxr = 1; ddr_area = 0; ddr_addr = 27'h20; ddr_size = 32'h1000; ddr_start = 1;
    waitreq = 0; txempty = 0; txdata = r128();
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      #1;
      if (rdack) n++;
      @(posedge clk); #1;
    end
    chk("rst_mid", n, 10);
    arst = 1; ddr_start = 0; txempty = 1;
    #1;
    chk("rst_async", all_out(), 321'd0);
    @(posedge clk); #1;
    chk("rst_next", all_out(), 321'd0);
    arst = 0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; seen = seen | int'(endp | busy | avm_read | avm_write); end
    chk("rst_quiet", seen, 0);
    run_cmd(1, 4'd0, 27'h20, 32'h300, 20, 20, NONE, 0, 0, NONE);
    for (int r = 0; r < 4; r++)
      run_cmd(1'($urandom), 4'($urandom), 27'($urandom), 32'($urandom_range(0, 32'h2000)),
              int'($urandom_range(0, 40)), int'($urandom_range(0, 30)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 30)), 0, NONE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    @(posedge clk);
    $finish;
  end
endmodule
